// File: rtl/bcd_pkg.sv
// Shared constants, state type and helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

    localparam int BIN_W_DEF  = 27;
    localparam int DIGITS_DEF = 8;
    localparam int CNT_W      = $clog2(BIN_W_DEF);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    // Largest value 10^n that the overflow compare needs; 64 bits covers any sane DIGITS.
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    localparam logic [63:0] BCD_LIMIT = pow10(DIGITS_DEF);

endpackage

// File: rtl/bcd_seq_converter_if.sv
// Handshake bundle between the binary source and the BCD converter.
// The ovf signal exists only when BCD_OVERFLOW_EN is defined.
interface bcd_seq_converter_if #(
    parameter int BIN_W  = bcd_pkg::BIN_W_DEF,
    parameter int DIGITS = bcd_pkg::DIGITS_DEF
);

    logic [BIN_W-1:0]    bin_in;
    logic                in_valid;
    logic                in_ready;
    logic [4*DIGITS-1:0] bcd_out;
    logic                out_valid;
`ifdef BCD_OVERFLOW_EN
    logic                ovf;

    modport master (
        output bin_in, in_valid,
        input  in_ready, bcd_out, out_valid, ovf
    );

    modport slave (
        input  bin_in, in_valid,
        output in_ready, bcd_out, out_valid, ovf
    );
`else
    modport master (
        output bin_in, in_valid,
        input  in_ready, bcd_out, out_valid
    );

    modport slave (
        input  bin_in, in_valid,
        output in_ready, bcd_out, out_valid
    );
`endif

endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble add-3 correction for one BCD nibble.
module bcd_digit_adj (
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    assign digit_out = (digit_in >= 4'd5) ? digit_in + 4'd3 : digit_in;

endmodule

// File: rtl/bcd_seq_converter.sv
// Multi-cycle double-dabble binary-to-BCD converter with valid/ready handshake.
// Optional BCD_OVERFLOW_EN adds an ovf flag and saturates out-of-range inputs to all 9s.
module bcd_seq_converter
    import bcd_pkg::*;
#(
    parameter int BIN_W  = BIN_W_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic               clk,
    input  logic               rst,
    bcd_seq_converter_if.slave bus
);

    localparam int CW   = $clog2(BIN_W);
    localparam int BCDW = 4 * DIGITS;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   count;
    logic [BIN_W-1:0] shreg;
    logic [BCDW-1:0] scratch;
    logic [BCDW-1:0] scratch_adj;
    logic [BCDW-1:0] scratch_shift;
    logic [BIN_W-1:0] shreg_shift;
    logic [BCDW+BIN_W-1:0] combined;
    logic [BCDW-1:0] final_value;
    logic [BCDW-1:0] bcd_q;
    logic            out_valid_q;
    logic            accept;
    logic            last_shift;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_in  (scratch[4*g +: 4]),
            .digit_out (scratch_adj[4*g +: 4])
        );
    end

    // The bit leaving the top digit is dropped, which leaves the result modulo 10^DIGITS.
    assign combined      = {scratch_adj, shreg} << 1;
    assign scratch_shift = combined[BCDW+BIN_W-1:BIN_W];
    assign shreg_shift   = combined[BIN_W-1:0];

    assign accept     = (state == IDLE) && bus.in_valid;
    assign last_shift = (state == SHIFT) && (count == CW'(BIN_W - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        bus.in_ready = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (last_shift) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef BCD_OVERFLOW_EN
    localparam logic [63:0] LIMIT = pow10(DIGITS);

    logic ovf_pend;
    logic ovf_q;

    // The range compare is taken once at accept so the shift path stays narrow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_pend <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            if (accept) begin
                ovf_pend <= (64'(bus.bin_in) >= LIMIT);
            end
            if (last_shift) begin
                ovf_q <= ovf_pend;
            end
        end
    end

    assign final_value = ovf_pend ? {DIGITS{4'h9}} : scratch_shift;
    assign bus.ovf     = ovf_q;
`else
    assign final_value = scratch_shift;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count       <= '0;
            shreg       <= '0;
            scratch     <= '0;
            bcd_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            if (accept) begin
                shreg   <= bus.bin_in;
                scratch <= '0;
                count   <= '0;
            end else if (state == SHIFT) begin
                shreg   <= shreg_shift;
                scratch <= scratch_shift;
                count   <= count + CW'(1);
                if (last_shift) begin
                    bcd_q       <= final_value;
                    out_valid_q <= 1'b1;
                end
            end
        end
    end

    assign bus.bcd_out   = bcd_q;
    assign bus.out_valid = out_valid_q;

endmodule
